instr_fetch: RTL and testbench

Instruction-fetch stage with an integrated IF/ID pipeline register, placed directly upstream of the main instruction decoder. It owns the PC, issues requests to a variable-latency instruction memory, and presents `instr_o` to the decoder. The top level slices `instr_o[31:26]` into the decoder opcode input and `instr_o[5:0]` into its funct input. It supports downstream stalls through a one-entry skid buffer, and supports branch/jump redirects that flush the pipeline and abandon any in-flight fetch.

---
 rtl/if_pkg.sv | 25 ++
 rtl/if_id_reg.sv | 45 ++++
 rtl/instr_fetch.sv | 135 +++++++++++++
 tb/tb_instr_fetch.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage and its neighbours.
//   if_state_e        : fetch FSM states (REQ, HOLD, DRAIN)
//   NOP_INSTR_DEFAULT : word presented to the decoder when IF/ID is empty
//   OP_*              : primary opcodes shared with the decoder
//   pc_next()         : sequential PC step, modulo 2^32
package if_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } if_state_e;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk_i, rst_i     : clock, asynchronous active-low reset
//   flush_i          : kill contents (valid 0, instr NOP); overrides everything
//   load_i           : capture instr_i/pc4_i as a valid instruction
//   hold_i           : keep current contents when not loading
//   instr_i, pc4_i   : incoming instruction word and its PC+4
//   instr_o, pc4_o, valid_o : registered IF/ID contents
// With neither load nor hold the register takes a bubble. pc4_o is left
// untouched by flush/bubble; it is only meaningful while valid_o is set.
module if_id_reg
  import if_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic        hold_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      instr_o <= NOP_INSTR;
      pc4_o   <= '0;
      valid_o <= 1'b0;
    end else if (flush_i) begin
      instr_o <= NOP_INSTR;
      valid_o <= 1'b0;
    end else if (load_i) begin
      instr_o <= instr_i;
      pc4_o   <= pc4_i;
      valid_o <= 1'b1;
    end else if (!hold_i) begin
      instr_o <= NOP_INSTR;
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, drives the variable-latency
// instruction memory, and feeds the decoder through the IF/ID register.
//   clk_i, rst_i              : clock, asynchronous active-low reset
//   stall_i                   : ID cannot accept; IF/ID holds
//   redirect_i, redirect_pc_i : taken branch / jump target (highest priority)
//   imem_req_o, imem_addr_o   : fetch request and address
//   imem_ready_i, imem_data_i : memory completion and instruction word
//   instr_o, pc4_o, valid_o   : IF/ID contents presented to the decoder
// A one-entry skid buffer absorbs a word that returns while ID is stalled.
// A redirect while a request is still waiting parks that address in
// drain_addr_q so the memory sees a stable address until it completes; the
// returned word is then discarded.
module instr_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  if_state_e   state_q;
  logic [31:0] pc_q;
  logic [31:0] drain_addr_q;
  logic [31:0] skid_instr_q;
  logic [31:0] skid_pc4_q;
  logic [31:0] pc_plus4;

  logic        ifid_flush;
  logic        ifid_load;
  logic        ifid_hold;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;

  assign pc_plus4 = pc_next(pc_q);

  // Request is forced low during reset so the memory never sees a fetch
  // before the stage is live.
  assign imem_req_o  = rst_i && (state_q != HOLD);
  assign imem_addr_o = (state_q == DRAIN) ? drain_addr_q : pc_q;

  always_comb begin
    ifid_flush = redirect_i;
    ifid_load  = 1'b0;
    ifid_hold  = stall_i;
    ifid_instr = imem_data_i;
    ifid_pc4   = pc_plus4;
    case (state_q)
      REQ: begin
        ifid_load = imem_ready_i && !stall_i;
      end
      HOLD: begin
        ifid_hold  = 1'b1;
        ifid_load  = !stall_i;
        ifid_instr = skid_instr_q;
        ifid_pc4   = skid_pc4_q;
      end
      default: begin
        // DRAIN: IF/ID was flushed on entry and stays empty.
        ifid_hold = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
    end else begin
      case (state_q)
        REQ: begin
          if (redirect_i) begin
            pc_q <= redirect_pc_i;
            if (!imem_ready_i) begin
              drain_addr_q <= pc_q;
              state_q      <= DRAIN;
            end
          end else if (imem_ready_i) begin
            pc_q <= pc_plus4;
            if (stall_i) begin
              skid_instr_q <= imem_data_i;
              skid_pc4_q   <= pc_plus4;
              state_q      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect_i) begin
            pc_q    <= redirect_pc_i;
            state_q <= REQ;
          end else if (!stall_i) begin
            state_q <= REQ;
          end
        end
        DRAIN: begin
          // A fresh redirect only retargets the PC; the old request must
          // still complete before the new address can be issued.
          if (redirect_i) pc_q <= redirect_pc_i;
          if (imem_ready_i) state_q <= REQ;
        end
        default: state_q <= REQ;
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (ifid_flush),
    .load_i  (ifid_load),
    .hold_i  (ifid_hold),
    .instr_i (ifid_instr),
    .pc4_i   (ifid_pc4),
    .instr_o (instr_o),
    .pc4_o   (pc4_o),
    .valid_o (valid_o)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by randomized traffic.
// The memory returns word_of(addr) for whatever address is presented. The
// reference is the program-order instruction stream: starting at the reset
// PC or a redirect target, each instruction the decoder accepts (valid_o
// with no stall and no redirect) must be the next sequential word.
module tb_instr_fetch;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic        clk;
  logic        rst_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_data_i;
  logic [31:0] instr_o;
  logic [31:0] pc4_o;
  logic        valid_o;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic [31:0] w_instr;
  logic [31:0] w_pc4;
  logic        w_valid;

  int          checks;
  int          failures;
  exp_t        exp_q[$];
  logic [31:0] next_pc;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a * 32'd3 + 32'h1357_9BDF;
  endfunction

  assign imem_data_i = word_of(imem_addr_o);
  assign w_data      = word_of(w_addr);

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ready_i (imem_ready_i),
    .imem_data_i  (imem_data_i),
    .instr_o      (instr_o),
    .pc4_o        (pc4_o),
    .valid_o      (valid_o)
  );

  // Second instance near the top of the address space, always-ready memory.
  instr_fetch #(
    .RESET_PC (32'hFFFF_FFFC),
    .NOP_INSTR(32'h0000_0000)
  ) dut_wrap (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (w_req),
    .imem_addr_o  (w_addr),
    .imem_ready_i (1'b1),
    .imem_data_i  (w_data),
    .instr_o      (w_instr),
    .pc4_o        (w_pc4),
    .valid_o      (w_valid)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Keeps the expected stream a few entries ahead of the decoder.
  task automatic topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{instr: word_of(next_pc), pc4: next_pc + 32'd4});
      next_pc = next_pc + 32'd4;
    end
  endtask

  task automatic restart_stream(input logic [31:0] start);
    exp_q.delete();
    next_pc = start;
    topup();
  endtask

  task automatic apply(input logic rdy, input logic stl, input logic rdr, input logic [31:0] tgt);
    imem_ready_i  = rdy;
    stall_i       = stl;
    redirect_i    = rdr;
    redirect_pc_i = tgt;
    if (rdr) restart_stream(tgt);
    else topup();
  endtask

  task automatic step(input logic rdy, input logic stl, input logic rdr, input logic [31:0] tgt);
    @(negedge clk);
    apply(rdy, stl, rdr, tgt);
    #2;
  endtask

  // Monitor: samples 3 time units after each falling edge, well away from
  // the rising edge at +10.
  initial begin : monitor
    logic        have_prev;
    logic        prev_req;
    logic        prev_rdy;
    logic [31:0] prev_addr;
    int          idle;
    exp_t        e;
    have_prev = 1'b0;
    prev_req  = 1'b0;
    prev_rdy  = 1'b0;
    prev_addr = '0;
    idle      = 0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_i) begin
        have_prev = 1'b0;
        idle      = 0;
      end else begin
        if (have_prev && prev_req && !prev_rdy && imem_req_o)
          chk("addr_stable", imem_addr_o, prev_addr);
        if (!redirect_i && valid_o && !stall_i) begin
          idle = 0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty: got instr %h with no expected entry", instr_o);
          end else begin
            e = exp_q.pop_front();
            chk("sb_instr", instr_o, e.instr);
            chk("sb_pc4", pc4_o, e.pc4);
          end
        end else begin
          idle++;
          if (idle == 64) begin
            checks++;
            failures++;
            $display("FAIL no_progress: got 64 idle cycles expected fewer");
            idle = 0;
          end
        end
        have_prev = 1'b1;
        prev_req  = imem_req_o;
        prev_rdy  = imem_ready_i;
        prev_addr = imem_addr_o;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL timeout: got no finish expected finish by 2000000");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    logic        rdy;
    logic        stl;
    logic        rdr;
    logic [31:0] tgt;
    checks        = 0;
    failures      = 0;
    next_pc       = '0;
    rst_i         = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_ready_i  = 1'b0;

    // Reset state
    @(negedge clk);
    #2;
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc4", pc4_o, 32'h0);
    chk("rst_wrap_pc4", w_pc4, 32'h0);

    // Zero-wait sequential fetch
    @(negedge clk);
    rst_i = 1'b1;
    restart_stream(32'h0);
    apply(1'b1, 1'b0, 1'b0, 32'h0);
    #2;
    chk("c0_req", {31'd0, imem_req_o}, 32'd1);
    chk("c0_addr", imem_addr_o, 32'h0);
    chk("c0_wrap_req", {31'd0, w_req}, 32'd1);
    chk("c0_wrap_addr", w_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("c1_addr", imem_addr_o, 32'h4);
    chk("c1_valid", {31'd0, valid_o}, 32'd1);
    chk("c1_instr", instr_o, word_of(32'h0));
    chk("c1_pc4", pc4_o, 32'h4);
    chk("wrap_pc4", w_pc4, 32'h0);
    chk("wrap_instr", w_instr, word_of(32'hFFFF_FFFC));
    chk("wrap_valid", {31'd0, w_valid}, 32'd1);
    chk("wrap_addr", w_addr, 32'h0);

    // Stall with skid: word at 8 arrives while stalled
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("c2_addr", imem_addr_o, 32'h8);
    chk("c2_instr", instr_o, word_of(32'h4));
    chk("c2_pc4", pc4_o, 32'h8);
    for (int unsigned i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("hold_req", {31'd0, imem_req_o}, 32'd0);
      chk("hold_instr", instr_o, word_of(32'h4));
    end
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("c5_req", {31'd0, imem_req_o}, 32'd0);
    chk("c5_instr", instr_o, word_of(32'h4));
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("c6_instr", instr_o, word_of(32'h8));
    chk("c6_pc4", pc4_o, 32'hC);
    chk("c6_addr", imem_addr_o, 32'hC);

    // Redirect while waiting at 16
    step(1'b0, 1'b0, 1'b1, 32'h40);
    chk("c7_addr", imem_addr_o, 32'h10);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("c8_valid", {31'd0, valid_o}, 32'd0);
    chk("c8_instr", instr_o, 32'h0);
    chk("c8_addr", imem_addr_o, 32'h10);
    chk("c8_req", {31'd0, imem_req_o}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("c9_addr", imem_addr_o, 32'h10);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("c10_addr", imem_addr_o, 32'h10);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("c11_addr", imem_addr_o, 32'h40);
    chk("c11_valid", {31'd0, valid_o}, 32'd0);

    // Redirect plus stall in HOLD
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("c12_instr", instr_o, word_of(32'h40));
    chk("c12_pc4", pc4_o, 32'h44);
    step(1'b0, 1'b1, 1'b1, 32'h100);
    chk("c13_req", {31'd0, imem_req_o}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("c14_valid", {31'd0, valid_o}, 32'd0);
    chk("c14_instr", instr_o, 32'h0);
    chk("c14_addr", imem_addr_o, 32'h100);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("c15_instr", instr_o, word_of(32'h100));
    chk("c15_pc4", pc4_o, 32'h104);

    // Asynchronous reset mid-DRAIN
    step(1'b0, 1'b0, 1'b1, 32'h200);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("drain_req", {31'd0, imem_req_o}, 32'd1);
    chk("drain_addr", imem_addr_o, 32'h104);
    #3;
    rst_i = 1'b0;
    #1;
    chk("arst_req", {31'd0, imem_req_o}, 32'd0);
    chk("arst_valid", {31'd0, valid_o}, 32'd0);
    chk("arst_instr", instr_o, 32'h0);
    chk("arst_pc4", pc4_o, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("arst_addr", imem_addr_o, 32'h0);

    // Randomized traffic
    @(negedge clk);
    rst_i = 1'b1;
    restart_stream(32'h0);
    apply(1'b1, 1'b0, 1'b0, 32'h0);
    for (int unsigned i = 0; i < 3000; i++) begin
      @(negedge clk);
      rdy = imem_req_o && ($urandom_range(0, 2) != 0);
      stl = ($urandom_range(0, 3) == 0);
      rdr = ($urandom_range(0, 19) == 0);
      tgt = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0;
      apply(rdy, stl, rdr, tgt);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
